// File: rtl/reg_file_pkg.sv
// Shared defaults and FSM state type for the reg_file register bank.
package reg_file_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/reg_word.sv
// One storage word of reg_file: load-enabled register with a clear input
// that takes priority over the write enable.
module reg_word #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] word_d;

  always_comb begin
    word_d = word_q;
    if (clr_i)     word_d = '0;
    else if (we_i) word_d = d_i;
  end

  // NOTE: storage words have no reset term; the parent's clear sweep zeroes
  // them one per cycle, and <= keeps every flop sampling pre-edge values.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign q_o = word_q;

endmodule

// File: rtl/reg_file.sv
// Two-read/one-write register file with a post-reset clear sweep.
// Define REG_FILE_BYPASS_EN for write-first collisions; default is read-first.
module reg_file
  import reg_file_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] in,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             busy
);

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;

  logic [DEPTH-1:0] clr_vec;
  logic [DEPTH-1:0] we_vec;
  logic [WIDTH-1:0] words [DEPTH];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        if (ptr_q == LAST_PTR) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      default: ;
    endcase
  end

  // Output logic: a reset edge itself clears entry 0, then the sweep walks ptr.
  always_comb begin
    busy    = (state_q == CLEAR);
    clr_vec = '0;
    we_vec  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (reset)                 clr_vec[i] = (i == 0);
      else if (state_q == CLEAR) clr_vec[i] = (32'(ptr_q) == i);
      we_vec[i] = !reset && (state_q == IDLE) && load && (32'(waddr) == i);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    reg_word #(.WIDTH(WIDTH)) u_word (
      .clk   (clk),
      .clr_i (clr_vec[g]),
      .we_i  (we_vec[g]),
      .d_i   (in),
      .q_o   (words[g])
    );
  end

  always_comb begin
    out_a_d = (32'(raddr_a) < DEPTH) ? words[raddr_a] : '0;
    out_b_d = (32'(raddr_b) < DEPTH) ? words[raddr_b] : '0;
`ifdef REG_FILE_BYPASS_EN
    if (load && (32'(waddr) < DEPTH) && (waddr == raddr_a)) out_a_d = in;
    if (load && (32'(waddr) < DEPTH) && (waddr == raddr_b)) out_b_d = in;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset || state_q == CLEAR) begin
      out_a_q <= '0;
      out_b_q <= '0;
    end else begin
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
    end
  end

  assign out_a = out_a_q;
  assign out_b = out_b_q;

endmodule
